// File: rtl/traffic_demand_scheduler_if.sv
// Sensor, green-status and demand/status signals between the scheduler,
// the raw detectors and the two-road light controller.
interface traffic_demand_scheduler_if;
    logic CAR_A;
    logic CAR_B;
    logic PED_A;
    logic PED_B;
    logic A_GREEN;
    logic B_GREEN;
    logic SA;
    logic SB;
    logic WAIT_A;
    logic WAIT_B;
    logic STARVE_A;
    logic STARVE_B;
    logic FAULT;

    modport master (
        output CAR_A, CAR_B, PED_A, PED_B, A_GREEN, B_GREEN,
        input  SA, SB, WAIT_A, WAIT_B, STARVE_A, STARVE_B, FAULT
    );

    modport slave (
        input  CAR_A, CAR_B, PED_A, PED_B, A_GREEN, B_GREEN,
        output SA, SB, WAIT_A, WAIT_B, STARVE_A, STARVE_B, FAULT
    );
endinterface

// File: rtl/traffic_demand_scheduler.sv
// Debounces car/ped inputs, latches per-phase demand and drives SA/SB of the
// two-road light controller while tracking its phase from the green status.
module traffic_demand_scheduler #(
    parameter int DEB_CYCLES = 4,
    parameter int WAIT_W     = 8,
    parameter int MAX_WAIT   = 30
) (
    input  logic CLK,
    input  logic RST,
    traffic_demand_scheduler_if.slave bus
);
    localparam int CW = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_SAT = '1;
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);

    localparam int I_CAR_A = 0;
    localparam int I_CAR_B = 1;
    localparam int I_PED_A = 2;
    localparam int I_PED_B = 3;

    typedef enum logic [1:0] {
        TRK_A = 2'd0,
        TRK_X = 2'd1,
        TRK_B = 2'd2,
        TRK_F = 2'd3
    } trk_t;

    logic [3:0] raw;
    logic [3:0] samp;
    logic [3:0] deb;
    logic [3:0] deb_q;
    logic [3:0][CW-1:0] cnt;

    trk_t state;
    trk_t state_nxt;
    logic enter_a;
    logic enter_b;
    logic to_fault;

    logic carreq_a;
    logic carreq_b;
    logic pedreq_a;
    logic pedreq_b;
    logic req_a;
    logic req_b;
    logic rise_ped_a;
    logic rise_ped_b;

    logic [WAIT_W-1:0] wait_a;
    logic [WAIT_W-1:0] wait_b;

    assign raw = {bus.PED_B, bus.PED_A, bus.CAR_B, bus.CAR_A};

    // One sampling flop per input, then a run-length debouncer.
    always_ff @(posedge CLK) begin
        if (RST) begin
            samp  <= '0;
            deb   <= '0;
            deb_q <= '0;
            cnt   <= '0;
        end else begin
            samp  <= raw;
            deb_q <= deb;
            for (int i = 0; i < 4; i++) begin
                if (samp[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    deb[i] <= samp[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign rise_ped_a = deb[I_PED_A] & ~deb_q[I_PED_A];
    assign rise_ped_b = deb[I_PED_B] & ~deb_q[I_PED_B];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= TRK_A;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            TRK_A: begin
                if (!bus.A_GREEN) state_nxt = TRK_X;
            end
            TRK_X: begin
                if (bus.B_GREEN) begin
                    state_nxt = TRK_B;
                end else if (bus.A_GREEN) begin
                    state_nxt = TRK_A;
                end
            end
            TRK_B: begin
                if (!bus.B_GREEN) state_nxt = TRK_X;
            end
            default: state_nxt = TRK_F;
        endcase
        if (bus.A_GREEN && bus.B_GREEN) state_nxt = TRK_F;
    end

    assign enter_a  = (state != TRK_A) && (state_nxt == TRK_A);
    assign enter_b  = (state != TRK_B) && (state_nxt == TRK_B);
    assign to_fault = (state_nxt == TRK_F);

    // Service clear wins over a same-cycle set; a lost button edge stays lost.
    always_ff @(posedge CLK) begin
        if (RST || to_fault) begin
            carreq_a <= 1'b0;
            carreq_b <= 1'b0;
            pedreq_a <= 1'b0;
            pedreq_b <= 1'b0;
        end else begin
            carreq_a <= !enter_a && (carreq_a || deb[I_CAR_A]);
            pedreq_b <= !enter_a && (pedreq_b || rise_ped_b);
            carreq_b <= !enter_b && (carreq_b || deb[I_CAR_B]);
            pedreq_a <= !enter_b && (pedreq_a || rise_ped_a);
        end
    end

    assign req_a = carreq_a | pedreq_b;
    assign req_b = carreq_b | pedreq_a;

    always_ff @(posedge CLK) begin
        if (RST) begin
            wait_a <= '0;
            wait_b <= '0;
        end else begin
            if (!req_a) begin
                wait_a <= '0;
            end else if (wait_a != WAIT_SAT) begin
                wait_a <= wait_a + 1'b1;
            end
            if (!req_b) begin
                wait_b <= '0;
            end else if (wait_b != WAIT_SAT) begin
                wait_b <= wait_b + 1'b1;
            end
        end
    end

    // Starve is gated by the live request so it drops one edge after a clear.
    always_ff @(posedge CLK) begin
        if (RST) begin
            bus.SA       <= 1'b0;
            bus.SB       <= 1'b0;
            bus.WAIT_A   <= 1'b0;
            bus.WAIT_B   <= 1'b0;
            bus.STARVE_A <= 1'b0;
            bus.STARVE_B <= 1'b0;
            bus.FAULT    <= 1'b0;
        end else begin
            bus.SA       <= (state == TRK_B) && req_a;
            bus.SB       <= (state == TRK_A) && req_b;
            bus.WAIT_A   <= pedreq_a;
            bus.WAIT_B   <= pedreq_b;
            bus.STARVE_A <= req_a && (wait_a >= WAIT_LIM);
            bus.STARVE_B <= req_b && (wait_b >= WAIT_LIM);
            bus.FAULT    <= (state == TRK_F);
        end
    end
endmodule

// File: tb/tb_traffic_demand_scheduler.sv
// Directed bench for traffic_demand_scheduler: cycle model compared on every
// negedge plus literal expectations at the timing points of each scenario.
module tb_traffic_demand_scheduler;
    localparam int DEB  = 4;
    localparam int MAXW = 30;
    localparam int WSAT = 255;

    localparam int PH_A = 0;
    localparam int PH_X = 1;
    localparam int PH_B = 2;
    localparam int PH_F = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;

    traffic_demand_scheduler_if bus();

    traffic_demand_scheduler #(
        .DEB_CYCLES(DEB),
        .WAIT_W(8),
        .MAX_WAIT(MAXW)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic act, input bit exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%b want=%b t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: window of the last DEB raw samples; the debounced value takes a
    // new level once the whole window disagrees with it.
    bit m_hist [4][DEB];
    bit m_deb [4];
    bit m_prev [4];
    int m_phase;
    bit m_car_a, m_car_b, m_ped_a, m_ped_b;
    int m_wait_a, m_wait_b;
    bit e_sa, e_sb, e_wa, e_wb, e_sta, e_stb, e_f;
    bit mvalid = 1'b0;

    always @(posedge clk) begin : model
        bit raw [4];
        bit ra, rb, ent_a, ent_b, rise_a, rise_b, flip;
        int nph;
        raw = '{bus.CAR_A, bus.CAR_B, bus.PED_A, bus.PED_B};
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                for (int k = 0; k < DEB; k++) m_hist[i][k] = 1'b0;
                m_deb[i]  = 1'b0;
                m_prev[i] = 1'b0;
            end
            m_phase = PH_A;
            {m_car_a, m_car_b, m_ped_a, m_ped_b} = '0;
            m_wait_a = 0;
            m_wait_b = 0;
            {e_sa, e_sb, e_wa, e_wb, e_sta, e_stb, e_f} = '0;
            mvalid = 1'b1;
        end else begin
            ra = m_car_a | m_ped_b;
            rb = m_car_b | m_ped_a;
            e_sb  = (m_phase == PH_A) && rb;
            e_sa  = (m_phase == PH_B) && ra;
            e_wa  = m_ped_a;
            e_wb  = m_ped_b;
            e_f   = (m_phase == PH_F);
            e_sta = ra && (m_wait_a >= MAXW);
            e_stb = rb && (m_wait_b >= MAXW);
            m_wait_a = ra ? ((m_wait_a < WSAT) ? m_wait_a + 1 : WSAT) : 0;
            m_wait_b = rb ? ((m_wait_b < WSAT) ? m_wait_b + 1 : WSAT) : 0;
            if (bus.A_GREEN && bus.B_GREEN) nph = PH_F;
            else if (m_phase == PH_A) nph = bus.A_GREEN ? PH_A : PH_X;
            else if (m_phase == PH_B) nph = bus.B_GREEN ? PH_B : PH_X;
            else if (m_phase == PH_X)
                nph = bus.B_GREEN ? PH_B : (bus.A_GREEN ? PH_A : PH_X);
            else nph = PH_F;
            ent_a  = (nph == PH_A) && (m_phase != PH_A);
            ent_b  = (nph == PH_B) && (m_phase != PH_B);
            rise_a = m_deb[2] && !m_prev[2];
            rise_b = m_deb[3] && !m_prev[3];
            if (nph == PH_F) begin
                {m_car_a, m_car_b, m_ped_a, m_ped_b} = '0;
            end else begin
                if (ent_a) begin
                    m_car_a = 1'b0;
                    m_ped_b = 1'b0;
                end else begin
                    m_car_a = m_car_a | m_deb[0];
                    m_ped_b = m_ped_b | rise_b;
                end
                if (ent_b) begin
                    m_car_b = 1'b0;
                    m_ped_a = 1'b0;
                end else begin
                    m_car_b = m_car_b | m_deb[1];
                    m_ped_a = m_ped_a | rise_a;
                end
            end
            for (int i = 0; i < 4; i++) begin
                m_prev[i] = m_deb[i];
                flip = 1'b1;
                for (int k = 0; k < DEB; k++)
                    if (m_hist[i][k] == m_deb[i]) flip = 1'b0;
                if (flip) m_deb[i] = !m_deb[i];
                for (int k = DEB - 1; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
                m_hist[i][0] = raw[i];
            end
            m_phase = nph;
        end
    end

    always @(negedge clk) begin
        if (mvalid) begin
            cmp("m_SA", bus.SA, e_sa);
            cmp("m_SB", bus.SB, e_sb);
            cmp("m_WAIT_A", bus.WAIT_A, e_wa);
            cmp("m_WAIT_B", bus.WAIT_B, e_wb);
            cmp("m_STARVE_A", bus.STARVE_A, e_sta);
            cmp("m_STARVE_B", bus.STARVE_B, e_stb);
            cmp("m_FAULT", bus.FAULT, e_f);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic all_zero(input string tag);
        cmp({tag, "_SA"}, bus.SA, 1'b0);
        cmp({tag, "_SB"}, bus.SB, 1'b0);
        cmp({tag, "_WAIT_A"}, bus.WAIT_A, 1'b0);
        cmp({tag, "_WAIT_B"}, bus.WAIT_B, 1'b0);
        cmp({tag, "_STARVE_A"}, bus.STARVE_A, 1'b0);
        cmp({tag, "_STARVE_B"}, bus.STARVE_B, 1'b0);
        cmp({tag, "_FAULT"}, bus.FAULT, 1'b0);
    endtask

    initial begin
        bus.CAR_A = 1'b0;
        bus.CAR_B = 1'b0;
        bus.PED_A = 1'b0;
        bus.PED_B = 1'b0;
        bus.A_GREEN = 1'b1;
        bus.B_GREEN = 1'b0;
        rst = 1'b1;
        tick(2);
        all_zero("rst");

        // pedestrian A: first sample at edge 0, SB/WAIT_A at edge 6
        rst = 1'b0;
        bus.PED_A = 1'b1;
        tick(6);
        cmp("ped_e5_SB", bus.SB, 1'b0);
        cmp("ped_e5_WAIT_A", bus.WAIT_A, 1'b0);
        tick(1);
        cmp("ped_e6_SB", bus.SB, 1'b1);
        cmp("ped_e6_WAIT_A", bus.WAIT_A, 1'b1);
        tick(3);
        bus.PED_A = 1'b0;
        bus.A_GREEN = 1'b0;
        tick(1);
        cmp("trkx_SB_hold", bus.SB, 1'b1);
        tick(1);
        cmp("trkx_SB_drop", bus.SB, 1'b0);
        tick(1);
        bus.B_GREEN = 1'b1;
        tick(1);
        cmp("trkb_WAIT_A_hold", bus.WAIT_A, 1'b1);
        tick(1);
        cmp("trkb_WAIT_A_drop", bus.WAIT_A, 1'b0);

        // bounce on PED_B: runs of 2 never qualify
        for (int i = 0; i < 10; i++) begin
            bus.PED_B = (i % 2 == 0);
            tick(2);
        end
        bus.PED_B = 1'b0;
        tick(6);
        cmp("bounce_WAIT_B", bus.WAIT_B, 1'b0);
        cmp("bounce_SA", bus.SA, 1'b0);
        cmp("bounce_STARVE_A", bus.STARVE_A, 1'b0);

        // back to phase A, then starve B with a parked car
        bus.B_GREEN = 1'b0;
        tick(1);
        bus.A_GREEN = 1'b1;
        tick(1);
        bus.CAR_B = 1'b1;
        tick(36);
        cmp("starve_e35", bus.STARVE_B, 1'b0);
        cmp("starve_e35_SB", bus.SB, 1'b1);
        tick(1);
        cmp("starve_e36", bus.STARVE_B, 1'b1);
        tick(3);
        bus.A_GREEN = 1'b0;
        tick(2);
        bus.B_GREEN = 1'b1;
        tick(1);
        cmp("starve_enter_b", bus.STARVE_B, 1'b1);
        tick(1);
        cmp("starve_cleared", bus.STARVE_B, 1'b0);
        bus.CAR_B = 1'b0;
        tick(8);

        // button edge collides with TRK_X -> TRK_B
        bus.B_GREEN = 1'b0;
        tick(2);
        bus.PED_A = 1'b1;
        tick(5);
        bus.B_GREEN = 1'b1;
        tick(1);
        cmp("coll_e5_WAIT_A", bus.WAIT_A, 1'b0);
        tick(1);
        cmp("coll_e6_WAIT_A", bus.WAIT_A, 1'b0);
        tick(3);
        cmp("coll_e9_WAIT_A", bus.WAIT_A, 1'b0);
        bus.PED_A = 1'b0;
        tick(2);

        // reset in the middle of a B request (wait_b = 12)
        bus.B_GREEN = 1'b0;
        tick(1);
        bus.A_GREEN = 1'b1;
        tick(1);
        bus.CAR_B = 1'b1;
        tick(18);
        cmp("midrst_SB_before", bus.SB, 1'b1);
        rst = 1'b1;
        tick(1);
        all_zero("midrst");
        rst = 1'b0;
        tick(6);
        cmp("requal_e5_SB", bus.SB, 1'b0);
        tick(1);
        cmp("requal_e6_SB", bus.SB, 1'b1);

        // both greens for one cycle -> sticky fault
        bus.B_GREEN = 1'b1;
        tick(1);
        cmp("fault_e0", bus.FAULT, 1'b0);
        bus.B_GREEN = 1'b0;
        bus.CAR_A = 1'b1;
        bus.PED_B = 1'b1;
        tick(1);
        cmp("fault_e1", bus.FAULT, 1'b1);
        cmp("fault_e1_SB", bus.SB, 1'b0);
        tick(10);
        cmp("fault_hold", bus.FAULT, 1'b1);
        cmp("fault_hold_SA", bus.SA, 1'b0);
        cmp("fault_hold_SB", bus.SB, 1'b0);
        cmp("fault_hold_WAIT_B", bus.WAIT_B, 1'b0);
        rst = 1'b1;
        tick(1);
        cmp("fault_rst", bus.FAULT, 1'b0);
        rst = 1'b0;
        bus.CAR_A = 1'b0;
        bus.PED_B = 1'b0;
        tick(6);
        cmp("post_fault_e5_SB", bus.SB, 1'b0);
        tick(1);
        cmp("post_fault_e6_SB", bus.SB, 1'b1);
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
